// File: rtl/locker_pkg.sv
// Shared types and defaults for the CI-LOCKER keypad sequencing controller.
package locker_pkg;

  // Status encoding doubles as the state encoding, so status is the state register itself.
  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    ERROR   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam int unsigned DIGIT_W = 32'd4;

  // Board defaults for a 50 MHz CLOCK_50.
  localparam logic [15:0] DEF_CODE      = 16'h2017;
  localparam int unsigned DEF_OPEN_CYC  = 32'd250_000_000;
  localparam int unsigned DEF_ERR_CYC   = 32'd100_000_000;
  localparam int unsigned DEF_LOCK_CYC  = 32'd1_500_000_000;

  // Width of the shared down-counter: enough to hold the largest load value (max-1).
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return ($clog2(m) < 32'd1) ? 32'd1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Synchroniser for an active-low, externally debounced push button.
// Produces a single-cycle pulse on each press (1->0 edge of the synchronised level).
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Two flops against metastability, a third to remember the previous synchronised level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  // A held button stays low, so prev==sync after one cycle and only one pulse results.
  assign pulse = prev_r & ~sync_r;

endmodule

// File: rtl/locker_seq_ctrl.sv
// Keypad lock sequencer: collects DIGITS digits, checks them against CODE and
// runs the timed OPEN / ERROR / LOCKOUT windows. Display encoding lives elsewhere.
module locker_seq_ctrl
  import locker_pkg::*;
#(
  parameter int unsigned         DIGITS    = 32'd4,
  parameter logic [4*DIGITS-1:0] CODE      = (4*DIGITS)'(DEF_CODE),
  parameter int unsigned         MAX_TRIES = 32'd3,
  parameter int unsigned         OPEN_CYC  = DEF_OPEN_CYC,
  parameter int unsigned         ERR_CYC   = DEF_ERR_CYC,
  parameter int unsigned         LOCK_CYC  = DEF_LOCK_CYC
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              validar,
  input  logic              cancel,
  input  logic [3:0]        SW,
  output logic [2:0]        status,
  output logic              unlock,
  output logic [3:0]        digit_cnt,
  output logic [DIGITS-1:0] digit_mask,
  output logic [3:0]        tries_left,
  output logic              busy
);

  localparam int unsigned ENTRY_W = DIGITS * DIGIT_W;
  localparam int unsigned TIMER_W = timer_width(OPEN_CYC, ERR_CYC, LOCK_CYC);

  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYC - 32'd1);
  localparam logic [TIMER_W-1:0] ERR_LOAD  = TIMER_W'(ERR_CYC - 32'd1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYC - 32'd1);
  localparam logic [3:0]         TRIES_MAX = 4'(MAX_TRIES);
  localparam logic [3:0]         LAST_IDX  = 4'(DIGITS - 32'd1);
  localparam logic [DIGITS-1:0]  MASK_ONE  = DIGITS'(1);

  logic               press_s;
  logic               clr_s;
  logic [3:0]         sw_meta_r;
  logic [3:0]         sw_sync_r;

  state_t             state_r;
  logic [ENTRY_W-1:0] entry_r;
  logic [3:0]         digit_cnt_r;
  logic [DIGITS-1:0]  digit_mask_r;
  logic [3:0]         tries_left_r;
  logic [TIMER_W-1:0] timer_r;
  logic               unlock_r;
  logic               busy_r;

  btn_edge_sync u_validar_sync (
    .clk   (CLOCK_50),
    .reset (reset),
    .btn   (validar),
    .pulse (press_s)
  );

  btn_edge_sync u_cancel_sync (
    .clk   (CLOCK_50),
    .reset (reset),
    .btn   (cancel),
    .pulse (clr_s)
  );

  // Digit switches get the same two-flop depth so SW lines up with the press pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sw_meta_r <= 4'd0;
      sw_sync_r <= 4'd0;
    end else begin
      sw_meta_r <= SW;
      sw_sync_r <= sw_meta_r;
    end
  end

  // Sequencer state, entry buffer, attempt counter, timer and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_r      <= ENTRY;
      entry_r      <= '0;
      digit_cnt_r  <= 4'd0;
      digit_mask_r <= '0;
      tries_left_r <= TRIES_MAX;
      timer_r      <= '0;
      unlock_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ENTRY: begin
          if (clr_s) begin
            entry_r      <= '0;
            digit_cnt_r  <= 4'd0;
            digit_mask_r <= '0;
          end else if (press_s) begin
            entry_r      <= (entry_r << DIGIT_W) | ENTRY_W'(sw_sync_r);
            digit_cnt_r  <= digit_cnt_r + 4'd1;
            digit_mask_r <= digit_mask_r | (MASK_ONE << digit_cnt_r);
            if (digit_cnt_r == LAST_IDX) begin
              state_r <= CHECK;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ENTRY;
            end
          end else begin
            state_r <= ENTRY;
          end
        end

        CHECK: begin
          entry_r      <= '0;
          digit_cnt_r  <= 4'd0;
          digit_mask_r <= '0;
          if (entry_r == CODE) begin
            state_r      <= OPEN;
            tries_left_r <= TRIES_MAX;
            timer_r      <= OPEN_LOAD;
            unlock_r     <= 1'b1;
            busy_r       <= 1'b0;
          end else if (tries_left_r > 4'd1) begin
            state_r      <= ERROR;
            tries_left_r <= tries_left_r - 4'd1;
            timer_r      <= ERR_LOAD;
            busy_r       <= 1'b1;
          end else begin
            // Final permitted failure: fail count saturates, nothing left to try.
            state_r      <= LOCKOUT;
            tries_left_r <= 4'd0;
            timer_r      <= LOCK_LOAD;
            busy_r       <= 1'b1;
          end
        end

        OPEN: begin
          if (clr_s || (timer_r == '0)) begin
            state_r  <= ENTRY;
            unlock_r <= 1'b0;
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end

        ERROR: begin
          if (timer_r == '0) begin
            state_r <= ENTRY;
            busy_r  <= 1'b0;
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end

        LOCKOUT: begin
          if (timer_r == '0) begin
            state_r      <= ENTRY;
            tries_left_r <= TRIES_MAX;
            busy_r       <= 1'b0;
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end

        default: begin
          state_r      <= ENTRY;
          entry_r      <= '0;
          digit_cnt_r  <= 4'd0;
          digit_mask_r <= '0;
          timer_r      <= '0;
          unlock_r     <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign status     = state_r;
  assign unlock     = unlock_r;
  assign digit_cnt  = digit_cnt_r;
  assign digit_mask = digit_mask_r;
  assign tries_left = tries_left_r;
  assign busy       = busy_r;

endmodule

// File: doc/locker_seq_ctrl.md
Name: locker_seq_ctrl

Overview:
- Sequencing controller for the CI-LOCKER keypad lock on the DE2 board.
- The user enters a DIGITS-long code one digit at a time. Each digit is set on SW[3:0] and committed with the active-low validar button.
- The block compares the entry against CODE and then either opens the lock for a timed window, shows a timed error, or enters a lockout after MAX_TRIES consecutive failures.
- It drives status and counter outputs consumed by the existing 7-segment and LED display logic. It does no segment encoding itself.

Parameters:
DIGITS, 4, number of 4-bit digits per code (range 1..8)
CODE, 16'h2017, expected code, width 4*DIGITS; the first digit entered is the most-significant nibble
MAX_TRIES, 3, consecutive failures that trigger lockout (range 1..15)
OPEN_CYC, 250_000_000, cycles the lock stays open (5 s at 50 MHz)
ERR_CYC, 100_000_000, cycles the error status is shown
LOCK_CYC, 1_500_000_000, cycles of lockout

Ports:
CLOCK_50  in  1  clock, 50 MHz
reset  in  1  reset, synchronous, active-low
validar  in  1  commit button, active-low, asynchronous to the clock, externally debounced
cancel  in  1  cancel/relock button, active-low, asynchronous, externally debounced
SW  in  4  digit value
status  out  3  0=ENTRY 1=CHECK 2=OPEN 3=ERROR 4=LOCKOUT
unlock  out  1  lock actuator enable; high only in OPEN
digit_cnt  out  4  digits entered so far in the current attempt
digit_mask  out  DIGITS  bit i set once digit i has been entered (display shows '-')
tries_left  out  4  MAX_TRIES minus consecutive failures
busy  out  1  high in CHECK, ERROR and LOCKOUT (inputs ignored)

Behaviour:
- Reset, sampled on the rising CLOCK_50 edge while reset==0, sets:
  - state ENTRY, entry register 0, digit_cnt 0, digit_mask 0
  - fail counter 0, so tries_left=MAX_TRIES
  - timer 0, unlock 0, status 0, busy 0
  - both input synchronisers set to 1 (released)
- Reset in any state, mid-operation, has exactly this effect: an open lock closes and a lockout is abandoned.
- Input conditioning:
  - validar, cancel and SW each pass through a 2-FF synchroniser, so they stay cycle-aligned.
  - press = sync_validar_prev & ~sync_validar, a 1-cycle pulse on the 1->0 edge. clr is derived the same way from cancel.
  - A held button yields exactly one pulse.
  - Latency is 3 cycles from a pin edge to the state/register update.
- ENTRY:
  - press & ~clr: shift the entry register left by 4, insert the synchronised SW, digit_cnt+1, set mask bit.
  - When that press completes digit DIGITS, the next state is CHECK.
  - clr in ENTRY: entry register, digit_cnt and mask go to 0. clr has priority over a simultaneous press.
- CHECK lasts exactly 1 cycle:
  - entry==CODE: go to OPEN, fail counter to 0, timer loads OPEN_CYC-1.
  - Mismatch, fail+1 < MAX_TRIES: go to ERROR, fail+1, timer loads ERR_CYC-1.
  - Mismatch, fail+1 == MAX_TRIES: go to LOCKOUT, fail counter saturates at MAX_TRIES, timer loads LOCK_CYC-1.
  - Leaving CHECK always clears the entry register, digit_cnt and digit_mask.
- OPEN:
  - unlock=1; the timer decrements each cycle.
  - At timer==0, return to ENTRY next cycle, so unlock is high for exactly OPEN_CYC cycles.
  - clr closes immediately: ENTRY next cycle.
  - press is ignored.
- ERROR: timed the same way with ERR_CYC; press and clr are ignored; returns to ENTRY.
- LOCKOUT:
  - Timed with LOCK_CYC; press and clr are ignored.
  - At expiry, fail counter goes to 0 and state goes to ENTRY.
- Timer:
  - Single down-counter, width $clog2(max(OPEN_CYC, ERR_CYC, LOCK_CYC)).
  - Never wraps; it is loaded only on a state entry.
- Fail counter:
  - Clears only on a successful CHECK, at LOCKOUT expiry, or on reset.
  - clr does not clear it.
- Outputs are registered: status, unlock and busy change on the same edge as the state.

Decomposition:
- Package locker_pkg:
  - state enum (ENTRY, CHECK, OPEN, ERROR, LOCKOUT) with the 3-bit encodings given for status
  - digit width constant (4)
  - default CODE and cycle constants for 50 MHz
- Sub-module btn_edge_sync: 2-FF synchroniser plus falling-edge pulse, instantiated for validar and cancel.
  - SW uses a plain 2-FF sync in the top module.

Test Plan:
Use DIGITS=4, CODE=16'h2017, MAX_TRIES=3, OPEN_CYC=8, ERR_CYC=4, LOCK_CYC=16 in every scenario.
1. Correct code: enter 2,0,1,7 (press on each) -> status steps 0 -> 1 (one cycle) -> 2; unlock=1 for exactly 8 cycles, then status=0; tries_left=3; digit_cnt=0.
2. Wrong code: enter 9,9,9,9 -> status 1 then 3 for 4 cycles, then 0; tries_left=2; a press during ERROR leaves digit_cnt=0.
3. Lockout: three wrong entries -> third CHECK goes to status 4; busy=1 for 16 cycles; presses ignored; afterwards tries_left=3.
4. Cancel: enter 2,0 then pulse cancel -> digit_cnt=0, digit_mask=0; then enter 2,0,1,7 -> OPEN. Press and cancel on the same cycle -> digit_cnt stays 0.
5. Relock and hold: in OPEN, pulse cancel at cycle 3 -> unlock=0 next cycle, status=0. Holding validar low for 20 cycles -> digit_cnt increments by exactly 1.
6. Reset mid-operation: assert reset=0 for 1 cycle during LOCKOUT -> next cycle status=0, unlock=0, tries_left=3, digit_cnt=0, digit_mask=0.
